// File: rtl/game_tick_scheduler.sv
// SpacyBird game-loop sequencer: phase FSM, tick prescaler and difficulty ramp.
// Each level-up shortens the tick interval until it reaches a floor.
module game_tick_scheduler #(
  parameter int START_PERIOD    = 7,
  parameter int MIN_PERIOD      = 3,
  parameter int STEP            = 2,
  parameter int TICKS_PER_LEVEL = 4,
  parameter int MAX_LEVEL       = 3,
  parameter int N               = $clog2(START_PERIOD + 1),
  parameter int L               = $clog2(MAX_LEVEL + 1)
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iStart,
  input  logic         iPause,
  input  logic         iCollision,
  output logic         oTick,
  output logic [L-1:0] oLevel,
  output logic [N-1:0] oPeriod,
  output logic [1:0]   oState,
  output logic         oGameOver
);

  localparam int TW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [N-1:0]  START_P   = N'(START_PERIOD);
  localparam logic [N-1:0]  MIN_P     = N'(MIN_PERIOD);
  localparam logic [N-1:0]  STEP_P    = N'(STEP);
  localparam logic [N:0]    DEC_FLOOR = (N + 1)'(MIN_PERIOD + STEP);
  localparam logic [L-1:0]  MAX_L     = L'(MAX_LEVEL);
  localparam logic [TW-1:0] TPL_LAST  = TW'(TICKS_PER_LEVEL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  presc_q, presc_d;
  logic [N-1:0]  period_q, period_d;
  logic [L-1:0]  level_q, level_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic          over_q, over_d;

  // Next-state, counter and difficulty logic.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    period_d   = period_q;
    level_d    = level_q;
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (iStart) begin
          state_d    = ST_RUN;
          presc_d    = '0;
          tick_cnt_d = '0;
          level_d    = '0;
          period_d   = START_P;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // Collision and pause both swallow a coinciding terminal compare.
        if (iCollision) begin
          state_d = ST_OVER;
        end else if (iPause) begin
          state_d = ST_PAUSE;
        end else if (presc_q >= period_q) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (tick_cnt_q == TPL_LAST) begin
            tick_cnt_d = '0;
            if (level_q != MAX_L) begin
              level_d = level_q + L'(1);
              if ({1'b0, period_q} >= DEC_FLOOR) begin
                period_d = period_q - STEP_P;
              end else begin
                period_d = MIN_P;
              end
            end else begin
              level_d = level_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end else begin
          presc_d = presc_q + N'(1);
        end
      end
      ST_PAUSE: begin
        if (iCollision) begin
          state_d = ST_OVER;
        end else if (iPause) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    over_d = (state_d == ST_OVER);
  end

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      period_q   <= START_P;
      level_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      level_q    <= level_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      over_q     <= over_d;
    end
  end

  assign oTick     = tick_q;
  assign oLevel    = level_q;
  assign oPeriod   = period_q;
  assign oState    = state_q;
  assign oGameOver = over_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: constant vector table, directed corner sequences,
// and random pulses checked against a tick-count based reference model.
module tb_game_tick_scheduler;

  localparam int START_PERIOD = 7;
  localparam int MIN_PERIOD = 3;
  localparam int STEP = 2;
  localparam int TPL = 4;
  localparam int MAX_LEVEL = 3;

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic       iStart = 1'b0;
  logic       iPause = 1'b0;
  logic       iCollision = 1'b0;
  logic       oTick;
  logic [1:0] oLevel;
  logic [2:0] oPeriod;
  logic [1:0] oState;
  logic       oGameOver;

  int total = 0;
  int bad = 0;

  // Reference model: phase, position within interval, ticks since game load.
  int m_st = 0;
  int m_el = 0;
  int m_tot = 0;
  int m_tick = 0;

  game_tick_scheduler #(
    .START_PERIOD(START_PERIOD), .MIN_PERIOD(MIN_PERIOD), .STEP(STEP),
    .TICKS_PER_LEVEL(TPL), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iPause(iPause),
    .iCollision(iCollision), .oTick(oTick), .oLevel(oLevel), .oPeriod(oPeriod),
    .oState(oState), .oGameOver(oGameOver)
  );

  always #5 iClk = ~iClk;

  function automatic int lvl_of(input int tot);
    int l;
    l = tot / TPL;
    return (l > MAX_LEVEL) ? MAX_LEVEL : l;
  endfunction

  function automatic int per_of(input int tot);
    int p;
    p = START_PERIOD - lvl_of(tot) * STEP;
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_el = 0; m_tot = 0; m_tick = 0;
  endtask

  task automatic model_edge(input logic s, input logic p, input logic c);
    m_tick = 0;
    case (m_st)
      0, 3: if (s) begin m_st = 1; m_el = 0; m_tot = 0; end
      1: begin
        if (c) m_st = 3;
        else if (p) m_st = 2;
        else if (m_el >= per_of(m_tot)) begin m_el = 0; m_tick = 1; m_tot++; end
        else m_el++;
      end
      2: if (c) m_st = 3; else if (p) m_st = 1;
      default: m_st = 0;
    endcase
  endtask

  task automatic step(input logic s, input logic p, input logic c);
    iStart = s; iPause = p; iCollision = c;
    @(posedge iClk);
    model_edge(s, p, c);
    #1;
    chk("model_state", int'(oState), m_st);
    chk("model_tick", int'(oTick), m_tick);
    chk("model_level", int'(oLevel), lvl_of(m_tot));
    chk("model_period", int'(oPeriod), per_of(m_tot));
    chk("model_over", int'(oGameOver), (m_st == 3) ? 1 : 0);
    iStart = 1'b0; iPause = 1'b0; iCollision = 1'b0;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    bit found;
    found = 0;
    n = 0;
    while (!found && n < maxc) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
      if (oTick) found = 1;
    end
    if (!found) chk("tick_timeout", 0, 1);
  endtask

  typedef struct {
    logic s, p, c;
    int st, tk, lv, pr, ov;
  } vec_t;

  vec_t vt[13];

  initial begin
    int n;
    // Expected values after each edge, starting straight after reset release.
    vt[0] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 7, 0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 7, 0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 7, 0};
    for (int i = 3; i <= 9; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 7, 0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 7, 0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 7, 0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 7, 0};

    #11;
    chk("reset_state", int'(oState), 0);
    chk("reset_tick", int'(oTick), 0);
    chk("reset_period", int'(oPeriod), 7);
    chk("reset_level", int'(oLevel), 0);
    chk("reset_over", int'(oGameOver), 0);
    iRstN = 1'b1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      step(vt[i].s, vt[i].p, vt[i].c);
      chk($sformatf("vec%0d_state", i), int'(oState), vt[i].st);
      chk($sformatf("vec%0d_tick", i), int'(oTick), vt[i].tk);
      chk($sformatf("vec%0d_level", i), int'(oLevel), vt[i].lv);
      chk($sformatf("vec%0d_period", i), int'(oPeriod), vt[i].pr);
      chk($sformatf("vec%0d_over", i), int'(oGameOver), vt[i].ov);
    end

    // Pause three counting edges after a tick, hold, then resume.
    wait_tick(20, n);
    chk("tick2_spacing", n, 6);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("pause_state", int'(oState), 2);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("pause_no_tick", int'(oTick), 0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("resume_state", int'(oState), 1);
    wait_tick(20, n);
    chk("resume_spacing", n, 5);

    wait_tick(20, n);
    chk("tick4_spacing", n, 8);
    chk("lvl1_level", int'(oLevel), 1);
    chk("lvl1_period", int'(oPeriod), 5);
    wait_tick(20, n);
    chk("lvl1_spacing", n, 6);

    // Drive through saturation.
    for (int i = 0; i < 7; i++) begin
      wait_tick(20, n);
      chk("level_cap", (oLevel <= 2'd3) ? 1 : 0, 1);
    end
    chk("sat_level", int'(oLevel), 3);
    chk("sat_period", int'(oPeriod), 3);
    wait_tick(20, n);
    chk("sat_spacing", n, 4);

    // Collision on the terminal-compare edge.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("col_tick", int'(oTick), 0);
    chk("col_state", int'(oState), 3);
    chk("col_over", int'(oGameOver), 1);
    step(1'b0, 1'b1, 1'b1);
    chk("over_hold_state", int'(oState), 3);
    chk("over_hold_level", int'(oLevel), 3);
    chk("over_hold_period", int'(oPeriod), 3);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_state", int'(oState), 1);
    chk("restart_level", int'(oLevel), 0);
    chk("restart_period", int'(oPeriod), 7);
    chk("restart_over", int'(oGameOver), 0);
    wait_tick(20, n);
    chk("restart_spacing", n, 8);

    // Asynchronous reset between edges.
    repeat (5) step(1'b0, 1'b0, 1'b0);
    #2 iRstN = 1'b0;
    #1;
    chk("async_state", int'(oState), 0);
    chk("async_level", int'(oLevel), 0);
    chk("async_period", int'(oPeriod), 7);
    chk("async_tick", int'(oTick), 0);
    chk("async_over", int'(oGameOver), 0);
    model_reset();
    #2 iRstN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("post_reset_no_tick", int'(oTick), 0);
    end

    // Random pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
